nv_vld_rdy_monitor: RTL and testbench

- Passive monitor on one valid/ready (vld/rdy) payload channel. Checks handshake protocol rules and keeps transfer statistics.
- Sits directly upstream of the X-checker assertion: mon_start drives its start_event and mon_pd drives its test_expr.
- Simulation/emulation checker only. It never drives the channel.

---
 rtl/nv_mon_pkg.sv | 24 ++
 rtl/nv_sat_cnt.sv | 36 +++
 rtl/nv_vld_rdy_monitor.sv | 155 +++++++++++++++
 tb/tb_nv_vld_rdy_monitor.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_mon_pkg.sv
// Shared types and constants for the vld/rdy channel monitor.
package nv_mon_pkg;

    // Handshake tracking state: IDLE until a stall starts, STALL while the payload is held.
    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } mon_state_e;

    // Bit positions of the sticky error flags.
    localparam int unsigned ERR_VLD_DROP = 0;
    localparam int unsigned ERR_PD_CHG   = 1;
    localparam int unsigned ERR_TIMEOUT  = 2;
    localparam int unsigned NUM_ERR      = 3;

    // Stall timer width: enough to hold max_stall, never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned max_stall);
        if (max_stall == 0) begin
            return 1;
        end
        return $clog2(max_stall + 1);
    endfunction

endpackage

// File: rtl/nv_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module nv_sat_cnt #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             inc,
    input  logic             clr,
    output logic [width-1:0] cnt
);

    logic [width-1:0] cnt_q;
    logic [width-1:0] cnt_d;

    // Next count: clear, or step up unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/nv_vld_rdy_monitor.sv
// Passive vld/rdy channel monitor: handshake rule checks, transfer pulse and statistics.
module nv_vld_rdy_monitor
    import nv_mon_pkg::*;
#(
    parameter int unsigned width     = 32,
    parameter int unsigned max_stall = 256,
    parameter int unsigned cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 enable,
    input  logic                 clr_err,
    input  logic                 vld,
    input  logic                 rdy,
    input  logic [width-1:0]     pd,
    output logic                 mon_start,
    output logic [width-1:0]     mon_pd,
    output logic                 err_vld_drop,
    output logic                 err_pd_chg,
    output logic                 err_timeout,
    output logic                 err_any,
    output logic [cnt_width-1:0] xfer_cnt,
    output logic [cnt_width-1:0] stall_cnt
);

    localparam int unsigned TIMER_W = timer_width(max_stall);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(max_stall);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((max_stall == 0) ? 0 : max_stall - 1);

    mon_state_e           state_q;
    mon_state_e           state_d;
    logic [width-1:0]     hold_pd_q;
    logic [width-1:0]     hold_pd_d;
    logic [width-1:0]     mon_pd_q;
    logic [width-1:0]     mon_pd_d;
    logic                 mon_start_q;
    logic                 mon_start_d;
    logic [NUM_ERR-1:0]   err_q;
    logic [NUM_ERR-1:0]   err_d;
    logic [NUM_ERR-1:0]   err_set;
    logic                 err_any_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 xfer_c;
    logic                 stall_c;
    logic                 timer_inc_c;

    // Qualified channel events; a disabled monitor sees neither.
    always_comb begin
        xfer_c      = enable & vld & rdy;
        stall_c     = enable & vld & ~rdy;
        timer_inc_c = stall_c & ((max_stall == 0) || (timer_q != TIMER_MAX));
    end

    // Next-state, protocol checks, sticky flag update and transfer capture.
    always_comb begin
        state_d     = state_q;
        hold_pd_d   = hold_pd_q;
        err_set     = '0;
        mon_start_d = xfer_c;
        mon_pd_d    = mon_pd_q;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vld && !rdy) begin
                        hold_pd_d = pd;
                        state_d   = STALL;
                    end
                end
                STALL: begin
                    // Reference stays the first stalled payload for the whole episode.
                    if (vld && (pd != hold_pd_q)) begin
                        err_set[ERR_PD_CHG] = 1'b1;
                    end
                    if (!vld) begin
                        err_set[ERR_VLD_DROP] = 1'b1;
                        state_d               = IDLE;
                    end else if (rdy) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end

        // Timer sits at max_stall-1 only on the cycle that completes the stall budget,
        // and then saturates at max_stall, so the flag is raised once per episode.
        if (stall_c && (max_stall != 0) && (timer_q == TIMER_LAST)) begin
            err_set[ERR_TIMEOUT] = 1'b1;
        end

        // A clear in the same cycle as a new error leaves that error set.
        err_d = clr_err ? '0 : err_q;
        err_d = err_d | err_set;

        if (xfer_c) begin
            mon_pd_d = pd;
        end
    end

    // State, reference payload, flags and transfer outputs.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= IDLE;
            hold_pd_q   <= '0;
            mon_start_q <= 1'b0;
            mon_pd_q    <= '0;
            err_q       <= '0;
            err_any_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_pd_q   <= hold_pd_d;
            mon_start_q <= mon_start_d;
            mon_pd_q    <= mon_pd_d;
            err_q       <= err_d;
            err_any_q   <= |err_d;
        end
    end

    // Accepted-transfer counter.
    nv_sat_cnt #(.width(cnt_width)) u_xfer_cnt (
        .clk    (clk),
        .reset_ (reset_),
        .inc    (xfer_c),
        .clr    (1'b0),
        .cnt    (xfer_cnt)
    );

    // Total stalled-cycle counter.
    nv_sat_cnt #(.width(cnt_width)) u_stall_cnt (
        .clk    (clk),
        .reset_ (reset_),
        .inc    (stall_c),
        .clr    (1'b0),
        .cnt    (stall_cnt)
    );

    // Length of the current stall episode; zero whenever the channel is not stalled.
    nv_sat_cnt #(.width(TIMER_W)) u_stall_timer (
        .clk    (clk),
        .reset_ (reset_),
        .inc    (timer_inc_c),
        .clr    (~stall_c),
        .cnt    (timer_q)
    );

    assign mon_start    = mon_start_q;
    assign mon_pd       = mon_pd_q;
    assign err_vld_drop = err_q[ERR_VLD_DROP];
    assign err_pd_chg   = err_q[ERR_PD_CHG];
    assign err_timeout  = err_q[ERR_TIMEOUT];
    assign err_any      = err_any_q;

endmodule

// File: tb/tb_nv_vld_rdy_monitor.sv
// Scoreboard bench for nv_vld_rdy_monitor: three configurations share one stimulus stream.
module tb_nv_vld_rdy_monitor;
    import nv_mon_pkg::*;

    logic        clk = 1'b0;
    logic        reset_;
    logic        enable;
    logic        clr_err;
    logic        vld;
    logic        rdy;
    logic [31:0] pd;

    // Instance A: max_stall 4; B: timeout disabled; C: 4-bit counters.
    logic        a_start, a_vd, a_pc, a_to, a_any;
    logic [31:0] a_pd;
    logic [15:0] a_xfer, a_stall;
    logic        b_start, b_vd, b_pc, b_to, b_any;
    logic [31:0] b_pd;
    logic [15:0] b_xfer, b_stall;
    logic        c_start, c_vd, c_pc, c_to, c_any;
    logic [31:0] c_pd;
    logic [3:0]  c_xfer, c_stall;

    always #5 clk = ~clk;

    nv_vld_rdy_monitor #(.width(32), .max_stall(4), .cnt_width(16)) u_dut_a (
        .clk(clk), .reset_(reset_), .enable(enable), .clr_err(clr_err),
        .vld(vld), .rdy(rdy), .pd(pd),
        .mon_start(a_start), .mon_pd(a_pd), .err_vld_drop(a_vd), .err_pd_chg(a_pc),
        .err_timeout(a_to), .err_any(a_any), .xfer_cnt(a_xfer), .stall_cnt(a_stall)
    );

    nv_vld_rdy_monitor #(.width(32), .max_stall(0), .cnt_width(16)) u_dut_b (
        .clk(clk), .reset_(reset_), .enable(enable), .clr_err(clr_err),
        .vld(vld), .rdy(rdy), .pd(pd),
        .mon_start(b_start), .mon_pd(b_pd), .err_vld_drop(b_vd), .err_pd_chg(b_pc),
        .err_timeout(b_to), .err_any(b_any), .xfer_cnt(b_xfer), .stall_cnt(b_stall)
    );

    nv_vld_rdy_monitor #(.width(32), .max_stall(256), .cnt_width(4)) u_dut_c (
        .clk(clk), .reset_(reset_), .enable(enable), .clr_err(clr_err),
        .vld(vld), .rdy(rdy), .pd(pd),
        .mon_start(c_start), .mon_pd(c_pd), .err_vld_drop(c_vd), .err_pd_chg(c_pc),
        .err_timeout(c_to), .err_any(c_any), .xfer_cnt(c_xfer), .stall_cnt(c_stall)
    );

    typedef struct packed {
        logic        start;
        logic [31:0] pd;
        logic [2:0]  err;
        logic        any;
        logic [15:0] xfer;
        logic [15:0] stall;
    } obs_t;
    typedef obs_t [2:0] obs3_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model state: stall run length (unbounded) and its first payload.
    int          run   [3];
    logic [31:0] refp  [3];
    obs_t        st    [3];
    int          ms    [3] = '{4, 0, 256};
    int          cmax  [3] = '{65535, 65535, 15};

    obs3_t       rec_q [$];
    logic [31:0] xq    [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t act_of(input int k);
        obs_t o;
        o = '0;
        case (k)
            0: begin
                o.start = a_start; o.pd = a_pd; o.err = {a_to, a_pc, a_vd}; o.any = a_any;
                o.xfer = a_xfer; o.stall = a_stall;
            end
            1: begin
                o.start = b_start; o.pd = b_pd; o.err = {b_to, b_pc, b_vd}; o.any = b_any;
                o.xfer = b_xfer; o.stall = b_stall;
            end
            default: begin
                o.start = c_start; o.pd = c_pd; o.err = {c_to, c_pc, c_vd}; o.any = c_any;
                o.xfer = 16'(c_xfer); o.stall = 16'(c_stall);
            end
        endcase
        return o;
    endfunction

    // Apply the channel rules for one clock edge using the inputs the bench drove.
    task automatic model_edge();
        obs3_t rec;
        logic  nd, np, nt;
        for (int k = 0; k < 3; k++) begin
            if (!reset_) begin
                run[k]  = 0;
                refp[k] = '0;
                st[k]   = '0;
            end else begin
                nd = 1'b0; np = 1'b0; nt = 1'b0;
                st[k].start = 1'b0;
                if (enable) begin
                    if (run[k] > 0 && vld && pd != refp[k]) np = 1'b1;
                    if (run[k] > 0 && !vld) nd = 1'b1;
                    if (vld && !rdy) begin
                        run[k] = run[k] + 1;
                        if (run[k] == 1) refp[k] = pd;
                        if (ms[k] != 0 && run[k] == ms[k]) nt = 1'b1;
                        if (int'(st[k].stall) < cmax[k]) st[k].stall = st[k].stall + 16'd1;
                    end else begin
                        run[k] = 0;
                    end
                    if (vld && rdy) begin
                        st[k].start = 1'b1;
                        st[k].pd    = pd;
                        if (int'(st[k].xfer) < cmax[k]) st[k].xfer = st[k].xfer + 16'd1;
                        if (k == 0) xq.push_back(pd);
                    end
                end else begin
                    run[k] = 0;
                end
                if (clr_err) st[k].err = '0;
                if (nd) st[k].err[ERR_VLD_DROP] = 1'b1;
                if (np) st[k].err[ERR_PD_CHG]   = 1'b1;
                if (nt) st[k].err[ERR_TIMEOUT]  = 1'b1;
                st[k].any = |st[k].err;
            end
            rec[k] = st[k];
        end
        rec_q.push_back(rec);
    endtask

    task automatic step(input logic en, input logic cl, input logic v, input logic r,
                        input logic [31:0] p);
        enable = en; clr_err = cl; vld = v; rdy = r; pd = p;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: one expected record per clock, plus payload pops on every transfer pulse.
    initial begin
        obs3_t       e;
        obs_t        a;
        logic [31:0] p;
        forever begin
            @(negedge clk);
            if (rec_q.size() > 0) begin
                e = rec_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    a = act_of(k);
                    chk($sformatf("i%0d.mon_start", k), 32'(a.start), 32'(e[k].start));
                    chk($sformatf("i%0d.mon_pd", k), a.pd, e[k].pd);
                    chk($sformatf("i%0d.err_flags", k), 32'(a.err), 32'(e[k].err));
                    chk($sformatf("i%0d.err_any", k), 32'(a.any), 32'(e[k].any));
                    chk($sformatf("i%0d.xfer_cnt", k), 32'(a.xfer), 32'(e[k].xfer));
                    chk($sformatf("i%0d.stall_cnt", k), 32'(a.stall), 32'(e[k].stall));
                end
            end
            if (a_start || b_start || c_start) begin
                if (xq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL xfer_unexpected: got mon_start=1 expected no transfer at %0t", $time);
                end else begin
                    p = xq.pop_front();
                    chk("xfer_pd_a", a_start ? a_pd : 32'hDEAD_BEEF, p);
                    chk("xfer_pd_b", b_start ? b_pd : 32'hDEAD_BEEF, p);
                    chk("xfer_pd_c", c_start ? c_pd : 32'hDEAD_BEEF, p);
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [31:0] cur;
        int          rdy_pct;
        obs_t        o;

        reset_ = 1'b0; enable = 1'b0; clr_err = 1'b0; vld = 1'b0; rdy = 1'b0; pd = '0;
        for (int k = 0; k < 3; k++) begin
            run[k] = 0; refp[k] = '0; st[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            o = act_of(k);
            chk($sformatf("reset_i%0d", k), 32'(o.start) | o.pd | 32'(o.err) | 32'(o.any)
                | 32'(o.xfer) | 32'(o.stall), 32'h0);
        end
        #2 reset_ = 1'b1;

        // Back-to-back transfers.
        step(1, 0, 1, 1, 32'h11);
        step(1, 0, 1, 1, 32'h22);
        step(1, 0, 1, 1, 32'h33);
        step(1, 0, 1, 1, 32'h44);
        chk("b2b_last_pd", a_pd, 32'h44);
        step(1, 0, 0, 0, 32'h0);
        chk("b2b_xfer_cnt", 32'(a_xfer), 32'd4);
        chk("b2b_stall_cnt", 32'(a_stall), 32'd0);
        chk("b2b_start_off", 32'(a_start), 32'd0);

        // Legal stall of three cycles.
        repeat (3) step(1, 0, 1, 0, 32'hA5);
        step(1, 0, 1, 1, 32'hA5);
        step(1, 0, 0, 0, 32'h0);
        chk("legal_stall_cnt", 32'(a_stall), 32'd3);
        chk("legal_mon_pd", a_pd, 32'hA5);
        chk("legal_no_err", 32'(a_any), 32'd0);

        // Payload change during a stall, then clear.
        step(1, 0, 1, 0, 32'hA5);
        step(1, 0, 1, 0, 32'hA6);
        chk("pd_chg_set", 32'(a_pc), 32'd1);
        chk("pd_chg_any", 32'(a_any), 32'd1);
        step(1, 0, 1, 1, 32'hA6);
        step(1, 1, 0, 0, 32'h0);
        chk("pd_chg_clr", 32'(a_pc), 32'd0);

        // Valid dropped during a stall, then clear.
        step(1, 0, 1, 0, 32'h7);
        step(1, 0, 0, 0, 32'h7);
        chk("vld_drop_set", 32'(a_vd), 32'd1);
        step(1, 1, 0, 0, 32'h0);
        chk("vld_drop_clr", 32'(a_any), 32'd0);

        // Clear coinciding with a new payload change: the error wins.
        step(1, 0, 1, 0, 32'h5);
        step(1, 1, 1, 0, 32'h6);
        chk("clr_vs_new_err", 32'(a_pc), 32'd1);
        step(1, 0, 1, 1, 32'h6);
        step(1, 1, 0, 0, 32'h0);

        // Ten-cycle stall: timeout on the fourth cycle, and never again in the episode.
        for (int i = 1; i <= 10; i++) begin
            step(1, (i == 5) ? 1'b1 : 1'b0, 1, 0, 32'h9);
            if (i == 3) chk("timeout_early", 32'(a_to), 32'd0);
            if (i == 4) chk("timeout_at_4", 32'(a_to), 32'd1);
        end
        chk("timeout_once", 32'(a_to), 32'd0);
        chk("timeout_disabled", 32'(b_to), 32'd0);
        step(1, 0, 1, 1, 32'h9);
        step(1, 1, 0, 0, 32'h0);

        // Asynchronous reset in the middle of a stall.
        step(1, 0, 1, 0, 32'h3);
        step(1, 0, 1, 0, 32'h3);
        @(negedge clk);
        #2 reset_ = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            o = act_of(k);
            chk($sformatf("async_reset_i%0d", k), 32'(o.start) | o.pd | 32'(o.err)
                | 32'(o.any) | 32'(o.xfer) | 32'(o.stall), 32'h0);
        end
        step(0, 0, 0, 0, 32'h0);
        reset_ = 1'b1;

        // Disabled monitor ignores a payload change and a handshake.
        step(1, 0, 1, 0, 32'hA5);
        step(0, 0, 1, 0, 32'hA6);
        step(0, 0, 1, 1, 32'hA6);
        chk("disabled_no_start", 32'(a_start), 32'd0);
        chk("disabled_no_err", 32'(a_any), 32'd0);
        chk("disabled_frozen_xfer", 32'(a_xfer), 32'd0);
        step(1, 0, 1, 1, 32'hA6);
        step(1, 0, 0, 0, 32'h0);

        // Counter saturation on the 4-bit instance.
        for (int i = 0; i < 20; i++) step(1, 0, 1, 1, 32'(i));
        step(1, 0, 0, 0, 32'h0);
        chk("sat_xfer_c", 32'(c_xfer), 32'd15);

        // Randomized traffic with varying backpressure.
        cur = $urandom;
        rdy_pct = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 10;
                    1:       rdy_pct = 50;
                    default: rdy_pct = 90;
                endcase
            end
            if ($urandom_range(0, 7) == 0) cur = $urandom;
            step(($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < rdy_pct) ? 1'b1 : 1'b0,
                 cur);
        end

        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        @(negedge clk);
        #1;
        chk("records_drained", 32'(rec_q.size()), 32'd0);
        chk("xfers_drained", 32'(xq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
